// File: rtl/spi_miso_deserializer.sv
// SPI master-side receive stage: synchronizes sclk/cs/miso0 onto pclk, samples MISO on
// the mode-dependent sclk edge, assembles DATA_WIDTH-bit words MSB- or LSB-first and
// hands them out through a valid/ready port with overrun and framing-error pulses.
// Build option: define SPI_RX_FIFO_EN to replace the single holding register with a
// FIFO_DEPTH-entry first-word-fall-through FIFO.
module spi_miso_deserializer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  miso0,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_bad_width
    $error("DATA_WIDTH must be in 4..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers plus history flops
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  logic sclk_s, cs_s, miso_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // Shift the pins into the synchronizer chains; history holds the previous last stage
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], miso0};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    miso_s      = miso_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    cs_rise     = cs_s & ~cs_hist_q;
    cs_fall     = ~cs_s & cs_hist_q;
  end

  // Synchronizer and history registers
  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      miso_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      miso_sync_q <= miso_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM and shifter
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic                  mode_cpol_q, mode_cpol_d;
  logic                  mode_cpha_q, mode_cpha_d;
  logic                  mode_lsb_q, mode_lsb_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  frame_err_q, frame_err_d;
  logic                  sample_edge;

  // Next-state logic: capture mode at cs fall, shift on sample edges, close words
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    mode_cpol_d = mode_cpol_q;
    mode_cpha_d = mode_cpha_q;
    mode_lsb_d  = mode_lsb_q;
    done_d      = 1'b0;
    word_d      = word_q;
    frame_err_d = 1'b0;
    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    sample_edge = (mode_cpol_q == mode_cpha_q) ? sclk_rise : sclk_fall;
    shifted     = mode_lsb_q ? {miso_s, shreg_q[DATA_WIDTH-1:1]}
                             : {shreg_q[DATA_WIDTH-2:0], miso_s};
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          mode_cpol_d = cpol;
          mode_cpha_d = cpha;
          mode_lsb_d  = lsb_first;
          cnt_d       = '0;
          shreg_d     = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (sample_edge) begin
          shreg_d = shifted;
          if (cnt_q == CntMax) begin
            cnt_d  = '0;
            done_d = 1'b1;
            word_d = shifted;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Evaluated after the edge so a cs rise on the final edge still completes the word
        if (cs_rise) begin
          frame_err_d = (cnt_d != '0);
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, shifter and completion registers
  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      mode_cpol_q <= 1'b0;
      mode_cpha_q <= 1'b0;
      mode_lsb_q  <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      mode_cpol_q <= mode_cpol_d;
      mode_cpha_q <= mode_cpha_d;
      mode_lsb_q  <= mode_lsb_d;
      done_q      <= done_d;
      word_q      <= word_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign busy      = (state_q == StShift);
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic pop;

  assign overrun = overrun_q;

`ifdef SPI_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]         rd_ptr_q, rd_ptr_d;
  logic                  empty, full;

  // FWFT FIFO: push on word completion unless full without a concurrent pop
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = 1'b0;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = ((wr_ptr_q - rd_ptr_q) == (PtrW + 1)'(FIFO_DEPTH));
    pop       = ~empty & rx_ready;
    if (done_q) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q[PtrW-1:0]] = word_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    rx_valid = ~empty;
    rx_data  = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
  end

  // FIFO storage and pointers
  always_ff @(posedge pclk) begin
    if (areset) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end
`else
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Holding register: a draining transfer frees the slot for a same-cycle new word
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    overrun_d    = 1'b0;
    pop          = hold_valid_q & rx_ready;
    if (done_q) begin
      if (!hold_valid_q || pop) begin
        hold_valid_d = 1'b1;
        hold_data_d  = word_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
    rx_valid = hold_valid_q;
    rx_data  = hold_data_q;
  end

  // Holding register state
  always_ff @(posedge pclk) begin
    if (areset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      overrun_q    <= overrun_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_miso_deserializer.sv
// Self-checking bench for spi_miso_deserializer with an SPI slave driver and a
// queue-based reference model of the words, errors and storage capacity.
module tb_spi_miso_deserializer;

  localparam int W    = 8;
  localparam int H    = 4;  // sclk half period in pclk cycles
  localparam int LAT  = 4;  // final pin edge to rx_valid rise (SYNC_STAGES + 2)
`ifdef SPI_RX_FIFO_EN
  localparam int CAP  = 4;
`else
  localparam int CAP  = 1;
`endif

  logic         pclk = 1'b0;
  logic         areset = 1'b1;
  logic         cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic         sclk = 1'b0, cs = 1'b1, miso0 = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b1;
  logic         overrun, frame_err, busy;

  spi_miso_deserializer dut (
    .pclk      (pclk),
    .areset    (areset),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .sclk      (sclk),
    .cs        (cs),
    .miso0     (miso0),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] tx_words[$];
  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];
  int n_ferr = 0, n_ovr = 0, n_wide = 0;
  int last_edge_cyc = 0, valid_rise_cyc = 0;
  logic ferr_prev = 1'b0, ovr_prev = 1'b0, valid_prev = 1'b0;

  // Monitor: sampled on the falling pclk edge, away from DUT updates
  always @(negedge pclk) begin
    if (!areset) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if ((frame_err && ferr_prev) || (overrun && ovr_prev)) n_wide++;
      if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
    end
    ferr_prev  = frame_err;
    ovr_prev   = overrun;
    valid_prev = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic clear_obs();
    got.delete();
    n_ferr = 0;
    n_ovr  = 0;
  endtask

  // Slave driver: sends nbits from tx_words in the chosen mode/order. rst_at >= 0
  // pulses areset before that bit and abandons the frame. cs_at_edge raises cs on the
  // final (trailing) sample edge; only meaningful with cpha = 1.
  task automatic spi_frame(input bit p, input bit h, input bit lsb, input int nbits,
                           input int rst_at, input bit cs_at_edge);
    logic [W-1:0] w;
    bit b;
    cpol = p; cpha = h; lsb_first = lsb; sclk = p;
    tick(8);
    cs = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        areset = 1'b1;
        tick(3);
        areset = 1'b0;
        cs = 1'b1;
        tick(8);
        return;
      end
      w = tx_words[i / W];
      b = lsb ? w[i % W] : w[W - 1 - (i % W)];
      if (!h) begin
        miso0 = b; tick(H);
        sclk = ~p; last_edge_cyc = cyc; tick(H);
        sclk = p;
      end else begin
        sclk = ~p; miso0 = b; tick(H);
        sclk = p; last_edge_cyc = cyc;
        if (cs_at_edge && i == nbits - 1) cs = 1'b1;
        tick(H);
      end
    end
    if (!cs_at_edge) begin
      tick(H);
      cs = 1'b1;
    end
    tick(10);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(3);
    areset = 1'b0;
    tick(1);
    vectors++; if (rx_data !== 8'h00) begin miscompares++;
      $display("FAIL reset_rx_data got %h want 00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++;
      $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_frame_err got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy got %b want 0", busy); end
    tick(8);
  endtask

  task automatic test_mode0();
    clear_obs();
    tx_words = '{8'hA5};
    spi_frame(1'b0, 1'b0, 1'b0, W, -1, 1'b0);
    vectors++; if (got.size() !== 1) begin miscompares++;
      $display("FAIL mode0_count got %0d want 1", got.size()); end
    else begin
      vectors++; if (got[0] !== 8'hA5) begin miscompares++;
        $display("FAIL mode0_data got %h want a5", got[0]); end
    end
    vectors++; if (valid_rise_cyc - last_edge_cyc !== LAT) begin miscompares++;
      $display("FAIL mode0_latency got %0d want %0d", valid_rise_cyc - last_edge_cyc, LAT); end
    vectors++; if (n_ferr !== 0 || n_ovr !== 0) begin miscompares++;
      $display("FAIL mode0_errors got ferr=%0d ovr=%0d want 0/0", n_ferr, n_ovr); end
  endtask

  task automatic test_modes();
    bit p_t[3]   = '{1'b1, 1'b0, 1'b1};
    bit h_t[3]   = '{1'b1, 1'b1, 1'b0};
    bit l_t[3]   = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] d_t[3] = '{8'hA5, 8'h3C, 8'h3C};
    for (int m = 0; m < 3; m++) begin
      clear_obs();
      tx_words = '{d_t[m]};
      spi_frame(p_t[m], h_t[m], l_t[m], W, -1, 1'b0);
      vectors++;
      if (got.size() !== 1 || got[0] !== d_t[m] || n_ferr !== 0) begin
        miscompares++;
        $display("FAIL mode_cpol%0d_cpha%0d got n=%0d data=%h ferr=%0d want n=1 data=%h ferr=0",
                 p_t[m], h_t[m], got.size(), (got.size() > 0) ? got[0] : 8'h00, n_ferr, d_t[m]);
      end
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    tx_words = '{8'hF0};
    spi_frame(1'b0, 1'b0, 1'b0, 5, -1, 1'b0);
    vectors++; if (n_ferr !== 1) begin miscompares++;
      $display("FAIL ferr_pulses got %0d want 1", n_ferr); end
    vectors++; if (got.size() !== 0 || rx_valid !== 1'b0) begin miscompares++;
      $display("FAIL ferr_no_word got n=%0d valid=%b want 0/0", got.size(), rx_valid); end
    clear_obs();
    tx_words = '{8'h5A};
    spi_frame(1'b0, 1'b0, 1'b0, W, -1, 1'b0);
    vectors++; if (got.size() !== 1 || got[0] !== 8'h5A || n_ferr !== 0) begin miscompares++;
      $display("FAIL ferr_next_frame got n=%0d ferr=%0d want 5a once, ferr 0", got.size(), n_ferr);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    tx_words.delete();
    for (int k = 0; k <= CAP; k++) tx_words.push_back(8'((k + 1) * ((CAP == 1) ? 8'h11 : 8'h01)));
    rx_ready = 1'b0;
    spi_frame(1'b0, 1'b0, 1'b0, W * (CAP + 1), -1, 1'b0);
    vectors++; if (n_ovr !== 1) begin miscompares++;
      $display("FAIL ovr_pulses got %0d want 1", n_ovr); end
    vectors++; if (rx_valid !== 1'b1 || rx_data !== tx_words[0]) begin miscompares++;
      $display("FAIL ovr_held got valid=%b data=%h want 1/%h", rx_valid, rx_data, tx_words[0]); end
    rx_ready = 1'b1;
    tick(CAP + 4);
    vectors++; if (got.size() !== CAP) begin miscompares++;
      $display("FAIL ovr_drain_count got %0d want %0d", got.size(), CAP); end
    else begin
      for (int k = 0; k < CAP; k++) begin
        vectors++; if (got[k] !== tx_words[k]) begin miscompares++;
          $display("FAIL ovr_drain_%0d got %h want %h", k, got[k], tx_words[k]); end
      end
    end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++;
      $display("FAIL ovr_empty got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_cs_at_edge();
    logic [W-1:0] d;
    clear_obs();
    d = 8'($urandom_range(0, 255));
    tx_words = '{d};
    spi_frame(1'b0, 1'b1, 1'b0, W, -1, 1'b1);
    vectors++; if (got.size() !== 1 || got[0] !== d || n_ferr !== 0) begin miscompares++;
      $display("FAIL cs_at_edge got n=%0d ferr=%0d want %h once, ferr 0", got.size(), n_ferr, d);
    end
  endtask

  task automatic test_busy_no_bits();
    clear_obs();
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    tick(8);
    cs = 1'b0;
    tick(6);
    vectors++; if (busy !== 1'b1) begin miscompares++;
      $display("FAIL busy_in_frame got %b want 1", busy); end
    cs = 1'b1;
    tick(10);
    vectors++; if (busy !== 1'b0 || n_ferr !== 0) begin miscompares++;
      $display("FAIL busy_empty_frame got busy=%b ferr=%0d want 0/0", busy, n_ferr); end
  endtask

  task automatic test_areset_mid();
    clear_obs();
    rx_ready = 1'b0;
    tx_words = '{8'h77};
    spi_frame(1'b0, 1'b0, 1'b0, W, -1, 1'b0);
    tx_words = '{8'hFF};
    spi_frame(1'b1, 1'b1, 1'b0, W, 4, 1'b0);
    vectors++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL areset_flush got valid=%b busy=%b want 0/0", rx_valid, busy); end
    rx_ready = 1'b1;
    clear_obs();
    tx_words = '{8'hC3};
    spi_frame(1'b0, 1'b0, 1'b0, W, -1, 1'b0);
    vectors++; if (got.size() !== 1 || got[0] !== 8'hC3 || n_ferr !== 0) begin miscompares++;
      $display("FAIL areset_next got n=%0d ferr=%0d want c3 once, ferr 0", got.size(), n_ferr);
    end
  endtask

  task automatic test_random();
    int nw, extra;
    bit p, h, l;
    for (int it = 0; it < 20; it++) begin
      clear_obs();
      p = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
      tx_words.delete();
      exp_q.delete();
      for (int k = 0; k < nw + 1; k++) tx_words.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < nw; k++) exp_q.push_back(tx_words[k]);
      spi_frame(p, h, l, nw * W + extra, -1, 1'b0);
      vectors++;
      if (got !== exp_q || n_ferr !== ((extra != 0) ? 1 : 0) || n_ovr !== 0) begin
        miscompares++;
        $display("FAIL random_%0d mode=%0d lsb=%0d got n=%0d ferr=%0d ovr=%0d want n=%0d ferr=%0d",
                 it, {p, h}, l, got.size(), n_ferr, n_ovr, exp_q.size(), (extra != 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_frame_err();
    test_overrun();
    test_cs_at_edge();
    test_busy_no_bits();
    test_areset_mid();
    test_random();
    vectors++; if (n_wide !== 0) begin miscompares++;
      $display("FAIL pulse_width got %0d wide pulses want 0", n_wide); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
